// File: rtl/ysyx_24080006_icache_assoc.sv
// N-way set-associative instruction cache with per-set round-robin replacement,
// fence.i invalidate, redirect flush and single-burst AXI line refill.
package ysyx_24080006_axi_pkg;
  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
  } axi_r_s2m_t;
endpackage

module ysyx_24080006_icache_assoc
  import ysyx_24080006_axi_pkg::*;
#(
  parameter int LINE_LOG2 = 5,
  parameter int SET_LOG2  = 5,
  parameter int WAYS      = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  input  logic        ifu_flush,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_resp_inst,
  input  logic        fence_i_valid,
  output logic        fence_i_ready,
  output axi_r_m2s_t  axi_r_o,
  input  axi_r_s2m_t  axi_r_i,
  output logic        perf_hit,
  output logic        perf_miss
);

  localparam int BEATS  = 1 << (LINE_LOG2 - 2);
  localparam int BEAT_W = LINE_LOG2 - 2;
  localparam int SETS   = 1 << SET_LOG2;
  localparam int SET_W  = (SET_LOG2 > 0) ? SET_LOG2 : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W  = 32 - LINE_LOG2 - SET_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    AR,
    R,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       addr_q;
  logic [WAY_W-1:0]  victim_q;
  logic [BEAT_W-1:0] beat_q;
  logic              drop_q;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_arr [WAYS][SETS];
  logic [31:0]       data_arr[WAYS][SETS][BEATS];

  logic [TAG_W-1:0]  cur_tag;
  logic [SET_W-1:0]  set_idx;
  logic [BEAT_W-1:0] cur_word;
  logic [WAYS-1:0]   hit_vec;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim_d;
  logic              hit;
  logic              rd_fire;
  logic              beat_last;
  logic              refill_done;
  logic              accept;
  logic              unused_bits;

  // The latched address drives every array index; the set field vanishes when SET_LOG2 is 0.
  assign cur_tag  = addr_q[31 -: TAG_W];
  assign set_idx  = SET_W'((addr_q >> LINE_LOG2) & 32'(SETS - 1));
  assign cur_word = addr_q[LINE_LOG2-1:2];

  assign accept      = (state_q == IDLE) && ifu_req_valid && !fence_i_valid;
  assign rd_fire     = (state_q == R) && axi_r_i.rvalid;
  assign beat_last   = axi_r_i.rlast || (beat_q == BEAT_W'(BEATS - 1));
  assign refill_done = rd_fire && beat_last;
  assign unused_bits = ^{addr_q[1:0], axi_r_i.rresp};

  // Tag compare across all ways, plus victim choice: lowest invalid way, else the RR pointer.
  always_comb begin
    hit_vec  = '0;
    hit_way  = '0;
    victim_d = rr_q[set_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_arr[w][set_idx] == cur_tag)) begin
        hit_vec[w] = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) victim_d = WAY_W'(w);
    end
  end

  assign hit = |hit_vec;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  state_d = hit ? IDLE : AR;
      AR:      if (axi_r_i.arready) state_d = R;
      R:       if (refill_done) state_d = (drop_q || ifu_flush) ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axi_r_o        = '0;
    ifu_resp_valid = 1'b0;
    ifu_resp_inst  = '0;
    perf_hit       = 1'b0;
    perf_miss      = 1'b0;
    ifu_req_ready  = (state_q == IDLE) && !fence_i_valid;
    fence_i_ready  = (state_q == IDLE) && fence_i_valid;
    unique case (state_q)
      LOOKUP: begin
        perf_hit  = hit;
        perf_miss = !hit;
        if (hit && !ifu_flush) begin
          ifu_resp_valid = 1'b1;
          ifu_resp_inst  = data_arr[hit_way][set_idx][cur_word];
        end
      end
      AR: begin
        axi_r_o.arvalid = 1'b1;
        axi_r_o.araddr  = {addr_q[31:LINE_LOG2], {LINE_LOG2{1'b0}}};
        axi_r_o.arlen   = 8'(BEATS - 1);
        axi_r_o.arsize  = 3'b010;
        axi_r_o.arburst = 2'b01;
      end
      R: axi_r_o.rready = 1'b1;
      RESP: begin
        if (!ifu_flush) begin
          ifu_resp_valid = 1'b1;
          ifu_resp_inst  = data_arr[victim_q][set_idx][cur_word];
        end
      end
      default: ;
    endcase
  end

  // Control state; the drop flag remembers a redirect seen while the refill is in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      victim_q <= '0;
      beat_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= ifu_req_addr;
        drop_q <= 1'b0;
      end
      if ((state_q == LOOKUP) && !hit) begin
        victim_q <= victim_d;
        beat_q   <= '0;
      end
      if (((state_q == AR) || (state_q == R)) && ifu_flush) drop_q <= 1'b1;
      if (rd_fire) beat_q <= beat_q + 1'b1;
    end
  end

  // Valid bits and RR pointers are the only array state that reset and fence.i touch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (fence_i_ready) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (refill_done) begin
      valid_q[set_idx][victim_q] <= 1'b1;
      if ((WAYS > 1) && (victim_q == rr_q[set_idx])) rr_q[set_idx] <= rr_q[set_idx] + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rd_fire) data_arr[victim_q][set_idx][beat_q] <= axi_r_i.rdata;
    if (refill_done) tag_arr[victim_q][set_idx] <= cur_tag;
  end

endmodule
